instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage; sits directly upstream of the decode/control logic.
//  Owns the PC, issues one-outstanding word requests to instruction memory and buffers returned words in a 2-entry FIFO.
//  Presents {Instr, instr_pc, PCPlus4} to decode with a valid/ready handshake.
//  Accepts PC redirects (branch/jump) from the execute stage and flushes wrong-path words.
// PARAMETERS
//  WIDTH     32             data/address width
//  RESET_PC  32'h0000_0000  first fetch address after reset
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  imem_req     out  1      request valid; held with imem_addr stable until imem_ack
//  imem_addr    out  WIDTH  word address (bits[1:0] always 00)
//  imem_ack     in   1      request complete; imem_rdata valid this cycle (may equal req cycle)
//  imem_rdata   in   WIDTH  returned instruction word
//  Instr        out  WIDTH  FIFO head instruction
//  instr_pc     out  WIDTH  address of Instr
//  PCPlus4      out  WIDTH  instr_pc + 4
//  jump_taken   out  1      head was already redirected by fetch (STATIC_JUMP_EN), else 0
//  instr_valid  out  1      FIFO head valid
//  instr_ready  in   1      decode accepts head; pop = instr_valid & instr_ready
//  redirect     in   1      flush and restart fetch at redirect_pc
//  redirect_pc  in   WIDTH  new PC (bits[1:0] ignored, forced 00)
// BEHAVIOUR
//  Reset: state=S_IDLE, imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, FIFO count=0, kill=0;
//   instr_valid=0, Instr/instr_pc/jump_taken=0, PCPlus4=4. Async reset mid-transaction drops imem_req at once; memory resets with us.
//  States:
//   S_IDLE  -> S_FETCH on first clk edge after rst_n release.
//   S_FETCH imem_req=1, imem_addr=req_addr (registered). On imem_ack: push word, pc/req_addr<=next_pc;
//           stay S_FETCH if (count_next<2) else S_STALL.
//   S_STALL imem_req=0; -> S_FETCH when count_next<2 (i.e. a pop occurs).
//   S_KILL  imem_req=1 on old req_addr; on imem_ack discard word, req_addr<=pc, -> S_FETCH.
//  Launch rule: new request only when post-pop count<2 -> in-flight word always has a free slot; no overflow possible.
//  next_pc = req_addr+4 (wraps mod 2^WIDTH at 32'hFFFF_FFFC -> 0).
//  Latency: zero-wait memory, ack in req cycle -> instr_valid next cycle; sustained 1 instr/cycle with instr_ready=1.
//  FIFO full (count=2): no request; empty: instr_valid=0. Push+pop same cycle: count unchanged, order preserved.
//  Redirect (highest priority, any state): FIFO flushed (count<=0, instr_valid=0 next cycle); pc<=redirect_pc.
//   S_FETCH w/o ack same cycle -> S_KILL (address held stable, word later discarded).
//   S_FETCH with ack same cycle -> word discarded, req_addr<=redirect_pc, stay S_FETCH.
//   S_STALL/S_IDLE-exit -> S_FETCH at redirect_pc. Redirect in S_KILL: pc updated, still await old ack.
//   Pop in redirect cycle still completes (decode took head), then flush.
// CONFIGURATION
//  STATIC_JUMP_EN defined: on non-discarded ack with imem_rdata[31:26]==6'b000010 (j), next_pc =
//   {req_addr_plus4[31:28], imem_rdata[25:0], 2'b00}; entry's jump_taken=1 so execute suppresses its redirect.
//  Undefined: next_pc always req_addr+4; jump_taken tied 0; jumps resolved by execute redirect.
// STRUCTURE
//  Shared package mips_pkg: opcode constants (OPC_J=6'b000010 etc., shared with decode), fetch state enum
//   {S_IDLE,S_FETCH,S_STALL,S_KILL}, RESET_PC default.
//  Sub-module fetch_fifo: 2-entry FIFO of {instr, pc, jump_taken}; push/pop/flush, count, full/empty.
// TESTING
//  1 Reset release, zero-wait mem, ready=1 -> addrs 0,4,8,...; instr_valid from cycle 2; one Instr/cycle, instr_pc matches.
//  2 ready=0 for 5 cycles -> exactly 2 words buffered, imem_req=0 in S_STALL; ready=1 -> words delivered in order, fetch resumes at 8.
//  3 Mem ack delayed 3 cycles, redirect to 0x100 in 2nd wait cycle -> addr held until ack, word dropped, next req addr 0x100.
//  4 Redirect to 0x40 same cycle as ack of 0x0C with 1 word buffered -> both dropped, next Instr has instr_pc=0x40.
//  5 STATIC_JUMP_EN, word at 0x10 = 0x0800_0020 -> next req addr 0x80, entry jump_taken=1; macro off -> next addr 0x14, jump_taken=0.
//  6 rst_n low while imem_req=1 awaiting ack -> imem_req=0 and instr_valid=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants (also used by decode), fetch FSM states
// and the default reset vector.
package mips_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STALL,
    S_KILL
  } fetch_state_t;

  function automatic logic is_jump_op(input logic [5:0] opcode);
    return opcode == OPC_J;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {instr, pc, jump_taken} records for the decode stage.
// Flush empties it in one cycle and wins over a simultaneous push.
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_instr,
  input  logic [WIDTH-1:0] push_pc,
  input  logic             push_jump,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_instr,
  output logic [WIDTH-1:0] head_pc,
  output logic             head_jump,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] instr_mem [0:1];
  logic [WIDTH-1:0] pc_mem    [0:1];
  logic             jump_mem  [0:1];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        jump_mem[i]  <= 1'b0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        instr_mem[wr_ptr] <= push_instr;
        pc_mem[wr_ptr]    <= push_pc;
        jump_mem[wr_ptr]  <= push_jump;
        wr_ptr            <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];
  assign head_jump  = jump_mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to instruction memory
// and buffers returned words for decode. Define STATIC_JUMP_EN to redirect on 'j' at fetch.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             jump_taken,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc
);

  fetch_state_t     state, state_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic [WIDTH-1:0] req_addr, req_n;
  logic [WIDTH-1:0] rpc;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] next_pc;
  logic             jump_hit;
  logic             push;
  logic             pop;
  logic [1:0]       fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] head_pc;
  logic             head_jump;
  logic [2:0]       cnt_after_push;
  logic [2:0]       cnt_after_pop;

  assign rpc    = redirect_pc & {{(WIDTH-2){1'b1}}, 2'b00};
  assign seq_pc = req_addr + WIDTH'(4);

`ifdef STATIC_JUMP_EN
  // An unconditional 'j' is resolved here so decode sees the target path directly.
  always_comb begin
    jump_hit = is_jump_op(imem_rdata[WIDTH-1:WIDTH-6]);
    next_pc  = jump_hit ? {seq_pc[WIDTH-1:WIDTH-4], imem_rdata[WIDTH-7:0], 2'b00} : seq_pc;
  end
`else
  always_comb begin
    jump_hit = 1'b0;
    next_pc  = seq_pc;
  end
`endif

  assign instr_valid    = ~fifo_empty;
  assign pop            = instr_valid & instr_ready;
  assign cnt_after_push = {1'b0, fifo_count} + 3'd1 - {2'b00, pop};
  assign cnt_after_pop  = {1'b0, fifo_count} - {2'b00, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_n;
    end
  end

  // A request is only launched when the post-pop count leaves room for its word,
  // so the in-flight word can always be pushed without overflow.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req_addr;
    push    = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_n = S_FETCH;
        if (redirect) begin
          pc_n  = rpc;
          req_n = rpc;
        end
      end
      S_FETCH: begin
        if (redirect) begin
          pc_n = rpc;
          if (imem_ack) req_n = rpc;
          else          state_n = S_KILL;
        end else if (imem_ack) begin
          push  = 1'b1;
          pc_n  = next_pc;
          req_n = next_pc;
          if (cnt_after_push >= 3'd2) state_n = S_STALL;
        end
      end
      S_STALL: begin
        if (redirect) begin
          pc_n    = rpc;
          req_n   = rpc;
          state_n = S_FETCH;
        end else if (cnt_after_pop < 3'd2) begin
          state_n = S_FETCH;
        end
      end
      S_KILL: begin
        if (redirect) pc_n = rpc;
        if (imem_ack) begin
          req_n   = redirect ? rpc : pc;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign imem_req  = (state == S_FETCH) || (state == S_KILL);
  assign imem_addr = req_addr;

  fetch_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (req_addr),
    .push_jump  (jump_hit),
    .pop        (pop),
    .flush      (redirect),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .head_jump  (head_jump),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign Instr      = instr_valid ? head_instr : '0;
  assign instr_pc   = instr_valid ? head_pc : '0;
  assign jump_taken = instr_valid & head_jump;
  assign PCPlus4    = instr_pc + WIDTH'(4);

endmodule
